// File: rtl/cis_line_emulator.sv
// Contact-image-sensor line emulator: on each accepted SI edge, emits a blanking
// lead-in followed by one line of per-channel test-pattern pixel words.
module cis_line_emulator #(
    parameter int CHANNELS   = 1,
    parameter int DATA_W     = 12,
    parameter int PIXELS     = 2592,
    parameter int LEAD       = 89,
    parameter int OFFSET_BIN = 1
) (
    input  logic                         CLK,
    input  logic                         RST,
    input  logic                         EN,
    input  logic                         SI,
    input  logic [1:0]                   MODE,
    input  logic [DATA_W-1:0]            START_VAL,
    input  logic [DATA_W-1:0]            STEP,
    output logic [CHANNELS*DATA_W-1:0]   DATA,
    output logic                         VALID,
    output logic [$clog2(PIXELS+1)-1:0]  PIX_IDX,
    output logic [15:0]                  LINE_CNT,
    output logic                         OVERRUN
);

    localparam int PIX_W     = $clog2(PIXELS+1);
    localparam int LEAD_W    = (LEAD > 1) ? $clog2(LEAD) : 1;
    localparam int LEAD_LAST = (LEAD > 0) ? LEAD - 1 : 0;
    localparam logic [PIX_W-1:0]  PIX_LAST = PIX_W'(PIXELS - 1);
    localparam logic [DATA_W-1:0] ENC_MASK = (OFFSET_BIN != 0) ? {1'b1, {(DATA_W-1){1'b0}}} : '0;

    typedef enum logic [1:0] {S_IDLE, S_LEAD, S_ACTIVE} state_t;

    state_t              state;
    logic                si_q;
    logic [LEAD_W-1:0]   lead_cnt;
    logic [1:0]          mode_r;
    logic [DATA_W-1:0]   start_r;
    logic [DATA_W-1:0]   step_r;
    logic [DATA_W-1:0]   acc;
    logic [DATA_W-1:0]   acc_next;
    logic [PIX_W-1:0]    pix_next;
    logic                si_edge;
    logic                last_pix;

    assign si_edge  = EN && SI && !si_q;
    assign last_pix = (PIX_IDX == PIX_LAST);
    assign acc_next = acc + step_r;
    assign pix_next = PIX_IDX + PIX_W'(1);

    // acc holds START_VAL + p*STEP for the current pixel, so the ramp never multiplies
    function automatic logic [DATA_W-1:0] pixel_word(
        input logic [1:0]        mode,
        input logic [PIX_W-1:0]  pix,
        input logic [DATA_W-1:0] ramp,
        input logic [DATA_W-1:0] base,
        input int                ch
    );
        logic [DATA_W+PIX_W-1:0] pix_ext;
        logic [DATA_W-1:0]       raw;
        pix_ext = (DATA_W+PIX_W)'(pix);
        case (mode)
            2'd0:    raw = ramp + DATA_W'(ch);
            2'd1:    raw = base;
            2'd2:    raw = pix[0] ? ~base : base;
            default: raw = pix_ext[DATA_W-1:0];
        endcase
        return raw ^ ENC_MASK;
    endfunction

    always_ff @(posedge CLK) begin
        if (RST) begin
            state    <= S_IDLE;
            si_q     <= 1'b0;
            lead_cnt <= '0;
            mode_r   <= '0;
            start_r  <= '0;
            step_r   <= '0;
            acc      <= '0;
            DATA     <= {CHANNELS{ENC_MASK}};
            VALID    <= 1'b0;
            PIX_IDX  <= '0;
            LINE_CNT <= '0;
            OVERRUN  <= 1'b0;
        end else begin
            si_q    <= SI;
            OVERRUN <= 1'b0;
            if (si_edge) begin
                // an edge landing on the final pixel completes that line rather than aborting it
                if (state == S_ACTIVE && last_pix)
                    LINE_CNT <= LINE_CNT + 16'd1;
                else if (state != S_IDLE)
                    OVERRUN <= 1'b1;
                mode_r   <= MODE;
                start_r  <= START_VAL;
                step_r   <= STEP;
                acc      <= START_VAL;
                lead_cnt <= '0;
                PIX_IDX  <= '0;
                if (LEAD == 0) begin
                    state <= S_ACTIVE;
                    VALID <= 1'b1;
                    for (int c = 0; c < CHANNELS; c++)
                        DATA[c*DATA_W +: DATA_W] <= pixel_word(MODE, '0, START_VAL, START_VAL, c);
                end else begin
                    state <= S_LEAD;
                    VALID <= 1'b0;
                    DATA  <= {CHANNELS{START_VAL ^ ENC_MASK}};
                end
            end else begin
                case (state)
                    S_LEAD: begin
                        if (lead_cnt == LEAD_W'(LEAD_LAST)) begin
                            state   <= S_ACTIVE;
                            VALID   <= 1'b1;
                            PIX_IDX <= '0;
                            for (int c = 0; c < CHANNELS; c++)
                                DATA[c*DATA_W +: DATA_W] <= pixel_word(mode_r, '0, start_r, start_r, c);
                        end else begin
                            lead_cnt <= lead_cnt + LEAD_W'(1);
                        end
                    end
                    S_ACTIVE: begin
                        if (last_pix) begin
                            state    <= S_IDLE;
                            VALID    <= 1'b0;
                            PIX_IDX  <= '0;
                            DATA     <= {CHANNELS{ENC_MASK}};
                            LINE_CNT <= LINE_CNT + 16'd1;
                        end else begin
                            PIX_IDX <= pix_next;
                            acc     <= acc_next;
                            for (int c = 0; c < CHANNELS; c++)
                                DATA[c*DATA_W +: DATA_W] <= pixel_word(mode_r, pix_next, acc_next, start_r, c);
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_cis_line_emulator.sv
// Directed testbench for cis_line_emulator: a two-channel default instance plus a
// short, zero-lead, straight-binary instance driven from the same inputs.
module tb_cis_line_emulator;

    localparam int LD  = 89;
    localparam int PIX = 2592;

    logic        clk = 1'b0;
    logic        rst, en, si;
    logic [1:0]  mode;
    logic [11:0] start_val, step;

    logic [23:0] data;
    logic        valid;
    logic [11:0] pix_idx;
    logic [15:0] line_cnt;
    logic        overrun;

    logic [11:0] data_b;
    logic        valid_b;
    logic [2:0]  pix_idx_b;
    logic [15:0] line_cnt_b;
    logic        overrun_b;

    int n_checks = 0;
    int n_pass   = 0;
    int exp_lines;

    typedef struct {
        string       name;
        logic [1:0]  mode;
        logic [11:0] start;
        logic [11:0] step;
        int          pix;
        logic [11:0] exp0;
        logic [11:0] exp1;
    } vec_t;

    vec_t vecs[8];

    always #5 clk = ~clk;

    cis_line_emulator #(.CHANNELS(2)) dut (
        .CLK(clk), .RST(rst), .EN(en), .SI(si), .MODE(mode),
        .START_VAL(start_val), .STEP(step), .DATA(data), .VALID(valid),
        .PIX_IDX(pix_idx), .LINE_CNT(line_cnt), .OVERRUN(overrun)
    );

    cis_line_emulator #(.CHANNELS(1), .PIXELS(4), .LEAD(0), .OFFSET_BIN(0)) dut_b (
        .CLK(clk), .RST(rst), .EN(en), .SI(si), .MODE(mode),
        .START_VAL(start_val), .STEP(step), .DATA(data_b), .VALID(valid_b),
        .PIX_IDX(pix_idx_b), .LINE_CNT(line_cnt_b), .OVERRUN(overrun_b)
    );

    task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    task automatic tick(input int n = 1);
        repeat (n) @(negedge clk);
    endtask

    // returns at the negedge just after the posedge that registered the SI edge
    task automatic apply_stimulus(input logic [1:0] m, input logic [11:0] s, input logic [11:0] st);
        mode = m; start_val = s; step = st;
        si = 1'b1;
        tick();
        si = 1'b0;
    endtask

    task automatic wait_valid(input logic level, input int bound, input string name);
        int k = 0;
        while (valid !== level && k < bound) begin
            tick();
            k++;
        end
        check_output(name, 32'(valid), 32'(level));
    endtask

    task automatic count_valid(input string name);
        int cnt = 0;
        while (valid === 1'b1 && cnt < 3000) begin
            cnt++;
            tick();
        end
        check_output(name, cnt, PIX);
    endtask

    initial begin
        vecs[0] = '{"ramp_p0",     2'd0, 12'h001, 12'h001, 0,    12'h801, 12'h802};
        vecs[1] = '{"ramp_last",   2'd0, 12'h001, 12'h001, 2591, 12'h220, 12'h221};
        vecs[2] = '{"ramp_wrap",   2'd0, 12'hFFE, 12'h001, 2,    12'h800, 12'h801};
        vecs[3] = '{"ramp_step3",  2'd0, 12'h100, 12'h003, 10,   12'h91E, 12'h91F};
        vecs[4] = '{"const",       2'd1, 12'h123, 12'h007, 7,    12'h923, 12'h923};
        vecs[5] = '{"checker_odd", 2'd2, 12'h0F0, 12'h000, 1,    12'h70F, 12'h70F};
        vecs[6] = '{"index",       2'd3, 12'h555, 12'h000, 300,  12'h92C, 12'h92C};
        vecs[7] = '{"step800",     2'd0, 12'h000, 12'h800, 3,    12'h000, 12'h001};

        rst = 1'b1; en = 1'b1; si = 1'b0; mode = 2'd0; start_val = '0; step = '0;
        tick(3);
        rst = 1'b0;
        check_output("rst_data",    data, 24'h800800);
        check_output("rst_valid",   32'(valid), 0);
        check_output("rst_pix",     pix_idx, 0);
        check_output("rst_lines",   line_cnt, 0);
        check_output("rst_overrun", 32'(overrun), 0);
        exp_lines = 0;
        tick(2);

        $display("[TB] line timing");
        apply_stimulus(2'd0, 12'h001, 12'h001);
        check_output("lead_data",  data, 24'h801801);
        check_output("lead_valid", 32'(valid), 0);
        tick(LD - 1);
        check_output("valid_before", 32'(valid), 0);
        tick();
        check_output("valid_rise", 32'(valid), 1);
        check_output("first_pix",  pix_idx, 0);
        check_output("first_data", data, 24'h802801);
        count_valid("valid_len");
        exp_lines++;
        check_output("idle_data",  data, 24'h800800);
        check_output("idle_lines", line_cnt, exp_lines);

        $display("[TB] vector table");
        foreach (vecs[i]) begin
            apply_stimulus(vecs[i].mode, vecs[i].start, vecs[i].step);
            tick(LD + vecs[i].pix);
            check_output(vecs[i].name, data, {vecs[i].exp1, vecs[i].exp0});
            check_output({vecs[i].name, "_idx"}, pix_idx, vecs[i].pix);
            wait_valid(1'b0, PIX + 10, {vecs[i].name, "_end"});
            exp_lines++;
            check_output({vecs[i].name, "_lines"}, line_cnt, exp_lines);
        end

        $display("[TB] controls frozen mid-line");
        apply_stimulus(2'd2, 12'h0F0, 12'h000);
        tick(LD);
        check_output("chk_p0", data, 24'h8F08F0);
        start_val = 12'h123; mode = 2'd1; step = 12'h005;
        tick();
        check_output("chk_p1", data, 24'h70F70F);
        tick();
        check_output("chk_p2", data, 24'h8F08F0);
        wait_valid(1'b0, PIX + 10, "chk_end");
        exp_lines++;

        $display("[TB] overrun");
        apply_stimulus(2'd0, 12'h001, 12'h001);
        tick(LD + 100);
        check_output("ovr_p100", data, 24'h866865);
        si = 1'b1;
        tick();
        si = 1'b0;
        check_output("ovr_pulse", 32'(overrun), 1);
        check_output("ovr_valid", 32'(valid), 0);
        check_output("ovr_pix",   pix_idx, 0);
        check_output("ovr_lines", line_cnt, exp_lines);
        tick();
        check_output("ovr_one_cycle", 32'(overrun), 0);
        tick(LD - 2);
        check_output("ovr_still_lead", 32'(valid), 0);
        tick();
        check_output("ovr_restart_valid", 32'(valid), 1);
        check_output("ovr_restart_pix",   pix_idx, 0);
        check_output("ovr_restart_data",  data, 24'h802801);
        wait_valid(1'b0, PIX + 10, "ovr_end");
        exp_lines++;
        check_output("ovr_end_lines", line_cnt, exp_lines);

        $display("[TB] edge on final pixel");
        apply_stimulus(2'd3, 12'h000, 12'h000);
        tick(LD + PIX - 1);
        check_output("end_last_data", data, 24'h21F21F);
        si = 1'b1;
        tick();
        si = 1'b0;
        exp_lines++;
        check_output("end_no_overrun", 32'(overrun), 0);
        check_output("end_lines",      line_cnt, exp_lines);
        check_output("end_lead_data",  data, 24'h800800);
        wait_valid(1'b1, LD + 10, "end_new_start");
        wait_valid(1'b0, PIX + 10, "end_new_end");
        exp_lines++;
        check_output("end_new_lines", line_cnt, exp_lines);

        $display("[TB] enable gating");
        begin
            int seen = 0;
            en = 1'b0;
            apply_stimulus(2'd0, 12'h001, 12'h001);
            for (int i = 0; i < 200; i++) begin
                tick();
                if (valid === 1'b1) seen++;
            end
            check_output("en0_no_valid", seen, 0);
            check_output("en0_lines", line_cnt, exp_lines);
        end
        en = 1'b1;
        apply_stimulus(2'd0, 12'h001, 12'h001);
        tick(50);
        en = 1'b0;
        wait_valid(1'b1, LD + 10, "endrop_start");
        wait_valid(1'b0, PIX + 10, "endrop_end");
        exp_lines++;
        check_output("endrop_lines", line_cnt, exp_lines);
        en = 1'b1;

        $display("[TB] reset mid-line");
        apply_stimulus(2'd0, 12'h001, 12'h001);
        tick(LD + 500);
        check_output("rstm_pix_before", pix_idx, 500);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check_output("rstm_valid", 32'(valid), 0);
        check_output("rstm_data",  data, 24'h800800);
        check_output("rstm_pix",   pix_idx, 0);
        check_output("rstm_lines", line_cnt, 0);
        exp_lines = 0;
        tick(2);
        apply_stimulus(2'd0, 12'h001, 12'h001);
        wait_valid(1'b1, LD + 10, "rstm_next_start");
        count_valid("rstm_next_len");
        exp_lines++;
        check_output("rstm_next_lines", line_cnt, exp_lines);

        $display("[TB] zero-lead straight-binary instance");
        apply_stimulus(2'd0, 12'hFFE, 12'h001);
        check_output("b_p0", data_b, 12'hFFE);
        check_output("b_valid0", 32'(valid_b), 1);
        tick();
        check_output("b_p1", data_b, 12'hFFF);
        tick();
        check_output("b_p2", data_b, 12'h000);
        tick();
        check_output("b_p3", data_b, 12'h001);
        check_output("b_idx3", pix_idx_b, 3);
        tick();
        check_output("b_idle_valid", 32'(valid_b), 0);
        check_output("b_idle_data",  data_b, 12'h000);
        wait_valid(1'b1, LD + 10, "b_tail_start");
        wait_valid(1'b0, PIX + 10, "b_tail_end");

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
